// File: rtl/dshot_frame_decoder.sv
// DShot single-line receiver: pulse-width bit slicing, 16-bit frame assembly, CRC, speed mapping and no-frame watchdog.
// Build option: define DSHOT_CRC_CHECK_EN to drop frames whose CRC nibble does not match.

module dshot_frame_decoder #(
  parameter int CLK_HZ      = 16000000,
  parameter int BIT_RATE    = 150000,
  parameter int TIMEOUT_CYC = 1600000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dshot_in,
  output logic [7:0]  speed,
  output logic [10:0] throttle,
  output logic        telem_req,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        failsafe
);
  localparam int BIT_CYC = CLK_HZ / BIT_RATE;
  localparam int THRESH  = BIT_CYC * 9 / 16;
  localparam int CW      = $clog2(2*BIT_CYC + 2);
  localparam int WW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LIM     = CW'(2*BIT_CYC);
  localparam logic [CW-1:0] CNT_MAX = CW'(2*BIT_CYC + 1);
  localparam logic [CW-1:0] THR_C   = CW'(THRESH);
  localparam logic [WW-1:0] WD_MAX  = WW'(TIMEOUT_CYC);

  typedef struct packed {
    logic [10:0] throttle;
    logic        telem;
    logic [3:0]  crc;
  } frame_t;

  typedef enum logic [2:0] {ST_SYNC, ST_IDLE, ST_HIGH, ST_LOW, ST_CHECK} state_t;

  state_t        state, state_nxt;
  logic          sync1, sync2;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  logic [4:0]    bit_cnt;
  frame_t        shreg;
  logic          shift_en, frame_clr, err, chk;
  logic          accept, crc_err;
  logic [7:0]    speed_map;
  logic [WW-1:0] wd_cnt, wd_nxt;

  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  assign wd_nxt  = (wd_cnt == WD_MAX) ? wd_cnt : wd_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      state <= ST_SYNC;
      cnt   <= '0;
    end else begin
      sync1 <= dshot_in;
      sync2 <= sync1;
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // cnt holds the length of the current level: loaded with 1 on the first
  // cycle of a level so that at the opposite edge it equals the level's clocks.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shift_en  = 1'b0;
    frame_clr = 1'b0;
    err       = 1'b0;
    chk       = 1'b0;
    case (state)
      ST_SYNC: begin
        if (sync2) cnt_nxt = '0;
        else begin
          cnt_nxt = cnt_inc;
          if (cnt_inc >= LIM) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
          end
        end
      end
      ST_IDLE: begin
        if (sync2) begin
          state_nxt = ST_HIGH;
          cnt_nxt   = CW'(1);
          frame_clr = 1'b1;
        end
      end
      ST_HIGH: begin
        if (!sync2) begin
          shift_en  = 1'b1;
          cnt_nxt   = CW'(1);
          state_nxt = (bit_cnt == 5'd15) ? ST_CHECK : ST_LOW;
        end else if (cnt > LIM) begin
          err       = 1'b1;
          cnt_nxt   = '0;
          state_nxt = ST_SYNC;
        end else cnt_nxt = cnt_inc;
      end
      ST_LOW: begin
        if (sync2) begin
          cnt_nxt   = CW'(1);
          state_nxt = ST_HIGH;
        end else if (cnt > LIM) begin
          err       = 1'b1;
          cnt_nxt   = '0;
          state_nxt = ST_IDLE;
        end else cnt_nxt = cnt_inc;
      end
      ST_CHECK: begin
        chk       = 1'b1;
        cnt_nxt   = '0;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (frame_clr) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (shift_en) begin
      shreg   <= {shreg[14:0], (cnt >= THR_C)};
      bit_cnt <= bit_cnt + 5'd1;
    end
  end

`ifdef DSHOT_CRC_CHECK_EN
  logic [11:0] crc_v;
  logic [3:0]  crc_calc;
  assign crc_v    = {shreg.throttle, shreg.telem};
  assign crc_calc = crc_v[3:0] ^ crc_v[7:4] ^ crc_v[11:8];
  assign accept   = chk && (crc_calc == shreg.crc);
  assign crc_err  = chk && (crc_calc != shreg.crc);
`else
  assign accept   = chk;
  assign crc_err  = 1'b0;
`endif

  // 1..47 are commands and leave the target speed alone
  always_comb begin
    speed_map = speed;
    if (shreg.throttle == 11'd0) speed_map = 8'd0;
    else if (shreg.throttle >= 11'd48) speed_map = 8'((shreg.throttle - 11'd48) >> 3);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      speed       <= 8'd0;
      throttle    <= 11'd0;
      telem_req   <= 1'b0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      failsafe    <= 1'b1;
      wd_cnt      <= '0;
    end else begin
      frame_valid <= accept;
      frame_err   <= err | crc_err;
      if (accept) begin
        throttle  <= shreg.throttle;
        telem_req <= shreg.telem;
        speed     <= speed_map;
        wd_cnt    <= '0;
        failsafe  <= 1'b0;
      end else begin
        wd_cnt <= wd_nxt;
        if (wd_nxt == WD_MAX) begin
          failsafe <= 1'b1;
          speed    <= 8'd0;
        end
      end
    end
  end
endmodule

// File: tb/tb_dshot_frame_decoder.sv
// Randomized bench for dshot_frame_decoder: drives DShot waveforms and compares every
// frame_valid/frame_err event against a frame-level reference model.
module tb_dshot_frame_decoder;
  localparam int TO = 5000;
`ifdef DSHOT_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0, dshot_in = 1'b0;
  logic [7:0]  speed;
  logic [10:0] throttle;
  logic        telem_req, frame_valid, frame_err, failsafe;

  dshot_frame_decoder #(.CLK_HZ(16000000), .BIT_RATE(150000), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .dshot_in(dshot_in), .speed(speed), .throttle(throttle),
    .telem_req(telem_req), .frame_valid(frame_valid), .frame_err(frame_err), .failsafe(failsafe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          c;
    logic        v;
    logic        e;
    logic [10:0] thr;
    logic        tel;
    logic [7:0]  spd;
    logic        fs;
  } ev_t;
  ev_t evq[$];

  always @(negedge clk)
    if (frame_valid || frame_err)
      evq.push_back('{cyc, frame_valid, frame_err, throttle, telem_req, speed, failsafe});

  int n_chk = 0, n_fail = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // reference model state (frame-level view of the outputs)
  int m_thr = 0, m_tel = 0, m_spd = 0, m_fs = 1, last_acc = 0, last_fall = 0;

  function automatic bit crc_good(input logic [15:0] f);
    int v;
    v = 32'(f) >> 4;
    return ((v ^ (v >> 4) ^ (v >> 8)) & 15) == (32'(f) & 15);
  endfunction

  function automatic logic [15:0] mk(input int thr, input int tel);
    int v;
    v = (thr << 1) | tel;
    return 16'((v << 4) | ((v ^ (v >> 4) ^ (v >> 8)) & 15));
  endfunction

  task automatic send_bit(input bit b);
    int h, l;
    h = b ? int'($urandom_range(72, 88)) : int'($urandom_range(32, 46));
    l = 106 - h + int'($urandom_range(0, 6)) - 3;
    dshot_in = 1'b1;
    repeat (h) @(negedge clk);
    dshot_in = 1'b0;
    last_fall = cyc;
    repeat (l) @(negedge clk);
  endtask

  task automatic send_frame(input logic [15:0] f, input int gap);
    for (int i = 15; i >= 0; i--) send_bit(f[i]);
    repeat (gap) @(negedge clk);
  endtask

  task automatic take_event(input string tag, output ev_t e, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400 && evq.size() == 0; i++) @(negedge clk);
    check({tag, "_evt_count"}, 32'(evq.size()), 1);
    if (evq.size() != 0) begin
      e  = evq.pop_front();
      ok = 1'b1;
    end
  endtask

  task automatic expect_frame(input string tag, input logic [15:0] f, input bit forced_err,
                              input bit chk_lat);
    ev_t e;
    bit  ok, acc;
    int  thr;
    take_event(tag, e, ok);
    if (!ok) return;
    if (m_fs == 0 && e.c - last_acc >= TO) begin
      m_fs  = 1;
      m_spd = 0;
    end
    acc = !forced_err && (crc_good(f) || !CRC_EN);
    if (acc) begin
      thr   = 32'(f[15:5]);
      m_thr = thr;
      m_tel = 32'(f[4]);
      if (thr == 0) m_spd = 0;
      else if (thr >= 48) m_spd = (thr - 48) / 8;
      m_fs     = 0;
      last_acc = e.c;
    end
    check({tag, "_valid"}, 32'(e.v), 32'(acc));
    check({tag, "_err"}, 32'(e.e), 32'(!acc));
    check({tag, "_throttle"}, 32'(e.thr), m_thr);
    check({tag, "_telem"}, 32'(e.tel), m_tel);
    check({tag, "_speed"}, 32'(e.spd), m_spd);
    check({tag, "_failsafe"}, 32'(e.fs), m_fs);
    if (chk_lat) check({tag, "_latency"}, e.c - last_fall, 4);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_speed"}, 32'(speed), 0);
    check({tag, "_throttle"}, 32'(throttle), 0);
    check({tag, "_telem"}, 32'(telem_req), 0);
    check({tag, "_valid"}, 32'(frame_valid), 0);
    check({tag, "_err"}, 32'(frame_err), 0);
    check({tag, "_failsafe"}, 32'(failsafe), 1);
  endtask

  initial begin
    logic [15:0] f;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    repeat (300) @(negedge clk);

    send_frame(16'h830B, 20);
    expect_frame("f830B", 16'h830B, 1'b0, 1'b1);
    check("f830B_thr_abs", 32'(throttle), 1048);
    check("f830B_spd_abs", 32'(speed), 125);

    send_frame(16'hFFEE, 10);
    expect_frame("fFFEE", 16'hFFEE, 1'b0, 1'b1);
    check("fFFEE_spd_abs", 32'(speed), 249);
    send_frame(16'h0000, 0);
    expect_frame("f0000", 16'h0000, 1'b0, 1'b1);
    send_frame(16'h830B, 5);
    expect_frame("f830B_b", 16'h830B, 1'b0, 1'b1);
    send_frame(16'h0154, 5);
    expect_frame("cmd10", 16'h0154, 1'b0, 1'b1);
    check("cmd10_spd_abs", 32'(speed), 125);
    send_frame(16'h830A, 5);
    expect_frame("badcrc", 16'h830A, 1'b0, 1'b1);

    // truncated frame: 8 bits, then the line stays low
    for (int i = 15; i >= 8; i--) send_bit(f_bit(16'h830B, i));
    repeat (300) @(negedge clk);
    expect_frame("trunc", 16'h0000, 1'b1, 1'b0);
    send_frame(16'h830B, 5);
    expect_frame("after_trunc", 16'h830B, 1'b0, 1'b1);

    // stuck-high line
    dshot_in = 1'b1;
    repeat (300) @(negedge clk);
    dshot_in = 1'b0;
    repeat (300) @(negedge clk);
    expect_frame("stuck", 16'h0000, 1'b1, 1'b0);
    send_frame(16'h830B, 5);
    expect_frame("after_stuck", 16'h830B, 1'b0, 1'b1);

    for (int n = 0; n < 16; n++) begin
      f = mk(int'($urandom_range(0, 2047)), int'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) f[3:0] = f[3:0] ^ 4'(1 + $urandom_range(0, 14));
      send_frame(f, int'($urandom_range(0, 80)));
      expect_frame($sformatf("rnd%0d", n), f, 1'b0, 1'b1);
    end

    // watchdog: silence after a valid frame
    send_frame(16'h830B, 5);
    expect_frame("wd_pre", 16'h830B, 1'b0, 1'b1);
    while (cyc < last_acc + TO - 1) @(negedge clk);
    check("wd_before_fs", 32'(failsafe), 0);
    check("wd_before_spd", 32'(speed), 125);
    @(negedge clk);
    check("wd_fs", 32'(failsafe), 1);
    check("wd_spd", 32'(speed), 0);
    m_fs  = 1;
    m_spd = 0;
    send_frame(16'h830B, 5);
    expect_frame("wd_recover", 16'h830B, 1'b0, 1'b1);

    // reset in the middle of a frame
    for (int i = 15; i >= 8; i--) send_bit(f_bit(16'hFFEE, i));
    rst_n    = 1'b0;
    dshot_in = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("midrst");
    check("midrst_no_evt", 32'(evq.size()), 0);
    evq.delete();
    rst_n = 1'b1;
    m_thr = 0; m_tel = 0; m_spd = 0; m_fs = 1;
    repeat (300) @(negedge clk);
    send_frame(16'h830B, 5);
    expect_frame("midrst_next", 16'h830B, 1'b0, 1'b1);

    repeat (20) @(negedge clk);
    check("final_no_stray", 32'(evq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  function automatic bit f_bit(input logic [15:0] f, input int i);
    return f[i];
  endfunction
endmodule

// File: doc/dshot_frame_decoder.md
# dshot_frame_decoder

Receives one DShot motor-control line, measures each bit's high time, assembles 16-bit frames, checks the CRC and produces a registered 8-bit target speed plus the raw 11-bit throttle. One instance per DShot input pin; it sits directly upstream of the PWM output and BLCtrl I2C stages, and its `speed` output drives their 8-bit target-speed inputs. A no-frame watchdog forces speed to 0 if the flight controller goes silent.

## Interface
- `CLK_HZ`, 16000000: system clock frequency.
- `BIT_RATE`, 150000: DShot bit rate. Derived: `BIT_CYC = CLK_HZ/BIT_RATE` (106), `THRESH = BIT_CYC*9/16` (59).
- `TIMEOUT_CYC`, 1600000: clocks without a valid frame before failsafe (100 ms).

- `clk` in 1: system clock. All logic is on the rising edge.
- `rst_n` in 1: synchronous reset, active-low.
- `dshot_in` in 1: asynchronous DShot line.
- `speed` out 8: target speed for downstream stages.
- `throttle` out 11: last accepted throttle/command value.
- `telem_req` out 1: telemetry bit of the last accepted frame.
- `frame_valid` out 1: one-cycle pulse when a frame is accepted.
- `frame_err` out 1: one-cycle pulse on a CRC, truncation or stuck-high error.
- `failsafe` out 1: high while no valid frame has arrived within `TIMEOUT_CYC`.

## Operation
- `dshot_in` passes through a 2-FF synchronizer. All edges and levels below refer to the synchronized signal.
- State machine with states SYNC, IDLE, HIGH, LOW and CHECK. Reset enters SYNC.
  - SYNC: waits until the line has been low for ≥ 2*`BIT_CYC` consecutive clocks, then goes to IDLE. A high level restarts the count.
  - IDLE: a rising edge clears the bit count and the shift register and enters HIGH.
  - HIGH: counts high clocks.
    - On a falling edge the bit value is 1 if count ≥ `THRESH`, else 0. The bit is shifted in MSB-first and the bit count increments.
    - If this was bit 16, go to CHECK; otherwise go to LOW.
    - If the count exceeds 2*`BIT_CYC`: pulse `frame_err`, go to SYNC.
  - LOW: counts low clocks.
    - A rising edge starts the next bit and enters HIGH.
    - If the count exceeds 2*`BIT_CYC` (truncated frame): pulse `frame_err`, go to IDLE.
  - CHECK: lasts one cycle, then goes to IDLE.
- Frame layout is `f[15:5]` throttle, `f[4]` telemetry, `f[3:0]` CRC. With `v = f[15:4]`, the CRC is `(v ^ v>>4 ^ v>>8) & 0xF`.
- On acceptance, `throttle` and `telem_req` load, `frame_valid` pulses, the watchdog clears and `failsafe` deasserts.
- Speed mapping on acceptance:
  - throttle 0 gives `speed` 0.
  - 1–47 are commands; `speed` is unchanged.
  - 48–2047 give `speed = (throttle-48)>>3`, range 0..249.
- Watchdog: counts every clock and saturates. On reaching `TIMEOUT_CYC` it sets `failsafe`=1 and `speed`=0. A subsequent valid frame overrides this in the same cycle.
- Reset values: `speed`=0, `throttle`=0, `telem_req`=0, `frame_valid`=0, `frame_err`=0, `failsafe`=1, watchdog count 0.
- A reset mid-frame discards the partial frame.
- Counter width is `$clog2(2*BIT_CYC+2)`; counters saturate and never wrap.

## Timing
- `frame_valid`/`frame_err` go high 4 clocks after the 16th falling edge at the pin: 2 sync + 1 HIGH decision + 1 CHECK. Outputs update in the same cycle the pulse is high.
- The minimum inter-frame low gap accepted is 0 extra clocks: IDLE is entered directly after CHECK.
- `frame_valid` and `frame_err` are never high in the same cycle.
- A watchdog expiry coinciding with acceptance resolves to acceptance: `failsafe`=0 and the new speed.

## Configuration
- `DSHOT_CRC_CHECK_EN` defined: a CRC mismatch drops the frame (no output update) and pulses `frame_err`.
- `DSHOT_CRC_CHECK_EN` undefined: the CRC is ignored and every complete 16-bit frame is accepted.

## Test plan
- Reset, then line low for 300 clocks, then frame 0x830B (throttle 1048, telem 0) → `frame_valid` pulse, `throttle`=1048, `speed`=125, `failsafe`=0.
- Frame 0xFFEE → `throttle`=2047, `speed`=249. Frame 0x0000 → `speed`=0.
- After `speed`=125, frame 0x0154 (command 10, telem 1) → `frame_valid`, `throttle`=10, `telem_req`=1, `speed` stays 125.
- Frame 0x830A with the macro defined → `frame_err` pulse, outputs unchanged. Same frame with the macro undefined → accepted, `speed`=125.
- 8 bits, then line low for 300 clocks → `frame_err` pulse and no output change. A following 0x830B is accepted normally.
- `TIMEOUT_CYC`=5000, one valid frame, then silence → `failsafe`=1 and `speed`=0 exactly 5000 clocks after `frame_valid`. The next 0x830B clears it.
